strobe_period_monitor: RTL and testbench

- Receiving end of the periodic enable strobe produced by the team's threshold counters.
- Samples a strobe on clock-enable-qualified cycles and measures the interval between strobes.
- Checks each interval against the expected period and tolerance, and declares lock after a run of good intervals.
- Used for bring-up and self-check of pixel/line/frame timing strobes in the video path.

---
 rtl/strobe_period_monitor.sv | 130 +++++++++++++
 tb/tb_strobe_period_monitor.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_period_monitor.sv
// Strobe interval checker with lock detection for periodic enable strobes.
// Define STROBE_MON_STICKY_ERR_EN to hold period_err high until reset.
module strobe_period_monitor #(
  parameter int EXPECTED_PERIOD = 10,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 4,
  parameter int PERIOD_WIDTH    = $clog2(EXPECTED_PERIOD + TOLERANCE + 2),
  parameter int ERR_WIDTH       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    strobe_in,
  output logic                    locked,
  output logic                    period_valid,
  output logic [PERIOD_WIDTH-1:0] measured_period,
  output logic                    period_err,
  output logic [ERR_WIDTH-1:0]    err_count
);

  localparam int GW    = $clog2(LOCK_COUNT + 1);
  localparam int MAX_P = EXPECTED_PERIOD + TOLERANCE;
  localparam int MIN_P = EXPECTED_PERIOD - TOLERANCE;

  localparam logic [PERIOD_WIDTH:0] MAX_V = (PERIOD_WIDTH+1)'(MAX_P);
  localparam logic [PERIOD_WIDTH:0] MIN_V = (PERIOD_WIDTH+1)'(MIN_P);
  localparam logic [GW-1:0]         LAST_GOOD = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t                state;
  logic [PERIOD_WIDTH-1:0] gap;
  logic [GW-1:0]         good_cnt;

  logic                  strobe_ev;
  logic                  active;
  logic [PERIOD_WIDTH:0] interval;
  logic                  good;
  logic                  timeout;
  logic                  meas_ev;
  logic                  err_ev;

  assign strobe_ev = clk_en & strobe_in;
  assign active    = (state != IDLE);
  assign interval  = {1'b0, gap} + (PERIOD_WIDTH+1)'(1);
  assign good      = (interval >= MIN_V) && (interval <= MAX_V);
  // Missing strobe: the running interval already exceeds the window.
  assign timeout   = clk_en & ~strobe_in & active & (interval > MAX_V);
  assign meas_ev   = strobe_ev & active;
  assign err_ev    = (meas_ev & ~good) | timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      gap             <= '0;
      good_cnt        <= '0;
      locked          <= 1'b0;
      period_valid    <= 1'b0;
      measured_period <= '0;
      period_err      <= 1'b0;
      err_count       <= '0;
    end else begin
      period_valid <= meas_ev;
      if (meas_ev)
        measured_period <= interval[PERIOD_WIDTH-1:0];

`ifdef STROBE_MON_STICKY_ERR_EN
      period_err <= period_err | err_ev;
`else
      period_err <= err_ev;
`endif

      if (err_ev && !(&err_count))
        err_count <= err_count + ERR_WIDTH'(1);

      if (clk_en) begin
        if (strobe_in || timeout)
          gap <= '0;
        else if (!(&gap))
          gap <= gap + PERIOD_WIDTH'(1);

        case (state)
          IDLE: begin
            if (strobe_in) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (strobe_in) begin
              if (!good) begin
                good_cnt <= '0;
              end else if (good_cnt == LAST_GOOD) begin
                good_cnt <= good_cnt + GW'(1);
                state    <= LOCKED;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else if (timeout) begin
              good_cnt <= '0;
              state    <= IDLE;
            end
          end
          LOCKED: begin
            if (strobe_in && !good) begin
              good_cnt <= '0;
              state    <= ACQUIRE;
              locked   <= 1'b0;
            end else if (timeout) begin
              good_cnt <= '0;
              state    <= IDLE;
              locked   <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Directed self-checking bench for strobe_period_monitor.
// Expectations for period_err follow STROBE_MON_STICKY_ERR_EN.
module tb_strobe_period_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       strobe_in = 1'b0;
  logic       locked;
  logic       period_valid;
  logic [3:0] measured_period;
  logic       period_err;
  logic [7:0] err_count;

  logic       locked2;
  logic       period_valid2;
  logic [3:0] measured_period2;
  logic       period_err2;
  logic [1:0] err_count2;

  int n_checks = 0;
  int n_fail = 0;
  int nvalid = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  strobe_period_monitor dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .strobe_in(strobe_in),
    .locked(locked),
    .period_valid(period_valid),
    .measured_period(measured_period),
    .period_err(period_err),
    .err_count(err_count)
  );

  strobe_period_monitor #(.ERR_WIDTH(2)) dut2 (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .strobe_in(strobe_in),
    .locked(locked2),
    .period_valid(period_valid2),
    .measured_period(measured_period2),
    .period_err(period_err2),
    .err_count(err_count2)
  );

  task automatic tick(input logic en, input logic s);
    clk_en = en;
    strobe_in = s;
    @(posedge clk);
    #1;
    if (period_valid) nvalid++;
    if (period_err) nerr++;
  endtask

  task automatic send_gap(input int n);
    for (int i = 0; i < n - 1; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    nvalid = 0;
    nerr = 0;
  endtask

  task automatic lock_up();
    do_reset();
    tick(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) send_gap(10);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_locked: got %0b want 0", locked);
    end
    n_checks++;
    if (period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %0b want 0", period_valid);
    end
    n_checks++;
    if (measured_period !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_period: got %0d want 0", measured_period);
    end
    n_checks++;
    if (period_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err: got %0b want 0", period_err);
    end
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_errcnt: got %0d want 0", err_count);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    n_checks++;
    if (nvalid !== 0) begin
      n_fail++;
      $display("FAIL lock_first_valid: got %0d want 0", nvalid);
    end
    for (int k = 0; k < 3; k++) send_gap(10);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: got %0b want 0", locked);
    end
    send_gap(10);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_locked: got %0b want 1", locked);
    end
    n_checks++;
    if (measured_period !== 4'd10) begin
      n_fail++;
      $display("FAIL lock_period: got %0d want 10", measured_period);
    end
    n_checks++;
    if (nvalid !== 4) begin
      n_fail++;
      $display("FAIL lock_nvalid: got %0d want 4", nvalid);
    end
    n_checks++;
    if (nerr !== 0) begin
      n_fail++;
      $display("FAIL lock_nerr: got %0d want 0", nerr);
    end
  endtask

  task automatic test_short_interval();
    lock_up();
    nerr = 0;
    send_gap(9);
    n_checks++;
    if (period_err !== 1'b1 || period_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL short_pulses: got err=%0b valid=%0b want 1 1",
               period_err, period_valid);
    end
    n_checks++;
    if (measured_period !== 4'd9) begin
      n_fail++;
      $display("FAIL short_period: got %0d want 9", measured_period);
    end
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL short_locked: got %0b want 0", locked);
    end
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL short_errcnt: got %0d want 1", err_count);
    end
    for (int k = 0; k < 4; k++) send_gap(10);
    n_checks++;
    if (locked !== 1'b1 || measured_period !== 4'd10) begin
      n_fail++;
      $display("FAIL short_relock: got locked=%0b per=%0d want 1 10",
               locked, measured_period);
    end
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL short_errcnt2: got %0d want 1", err_count);
    end
`ifdef STROBE_MON_STICKY_ERR_EN
    n_checks++;
    if (period_err !== 1'b1 || nerr !== 41) begin
      n_fail++;
      $display("FAIL short_sticky: got err=%0b cycles=%0d want 1 41",
               period_err, nerr);
    end
`else
    n_checks++;
    if (period_err !== 1'b0 || nerr !== 1) begin
      n_fail++;
      $display("FAIL short_pulse: got err=%0b cycles=%0d want 0 1",
               period_err, nerr);
    end
`endif
  endtask

  task automatic test_timeout();
    lock_up();
    nerr = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    n_checks++;
    if (nerr !== 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL to_early: got errs=%0d locked=%0b want 0 1",
               nerr, locked);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (period_err !== 1'b1 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse: got err=%0b valid=%0b want 1 0",
               period_err, period_valid);
    end
    n_checks++;
    if (locked !== 1'b0 || measured_period !== 4'd10) begin
      n_fail++;
      $display("FAIL to_state: got locked=%0b per=%0d want 0 10",
               locked, measured_period);
    end
    nvalid = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    n_checks++;
    if (nvalid !== 0 || locked !== 1'b0 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL to_restart: got valids=%0d locked=%0b errs=%0d want 0 0 1",
               nvalid, locked, err_count);
    end
`ifdef STROBE_MON_STICKY_ERR_EN
    n_checks++;
    if (period_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky: got %0b want 1", period_err);
    end
`else
    n_checks++;
    if (period_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse_end: got %0b want 0", period_err);
    end
`endif
    for (int k = 0; k < 4; k++) send_gap(10);
    n_checks++;
    if (locked !== 1'b1 || nvalid !== 4) begin
      n_fail++;
      $display("FAIL to_relock: got locked=%0b valids=%0d want 1 4",
               locked, nvalid);
    end
  endtask

  task automatic qtick(input logic s);
    tick(1'b0, s);
    tick(1'b0, s);
    tick(1'b1, s);
  endtask

  task automatic test_clk_en();
    do_reset();
    qtick(1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) qtick(1'b0);
      qtick(1'b1);
    end
    n_checks++;
    if (locked !== 1'b1 || measured_period !== 4'd10) begin
      n_fail++;
      $display("FAIL cen_lock: got locked=%0b per=%0d want 1 10",
               locked, measured_period);
    end
    n_checks++;
    if (nvalid !== 4 || nerr !== 0) begin
      n_fail++;
      $display("FAIL cen_counts: got valids=%0d errs=%0d want 4 0",
               nvalid, nerr);
    end
  endtask

  task automatic test_reset_mid();
    lock_up();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    do_reset();
    n_checks++;
    if (locked !== 1'b0 || measured_period !== 4'd0 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got locked=%0b per=%0d valid=%0b want 0 0 0",
               locked, measured_period, period_valid);
    end
    tick(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) send_gap(10);
    n_checks++;
    if (locked !== 1'b1 || nvalid !== 4 || nerr !== 0) begin
      n_fail++;
      $display("FAIL mid_relock: got locked=%0b valids=%0d errs=%0d want 1 4 0",
               locked, nvalid, nerr);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    tick(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) send_gap(9);
    n_checks++;
    if (err_count !== 8'd3 || err_count2 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_3: got %0d/%0d want 3/3", err_count, err_count2);
    end
    for (int k = 0; k < 2; k++) send_gap(9);
    n_checks++;
    if (err_count !== 8'd5) begin
      n_fail++;
      $display("FAIL sat_cnt8: got %0d want 5", err_count);
    end
    n_checks++;
    if (err_count2 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_cnt2: got %0d want 3", err_count2);
    end
    n_checks++;
    if (locked !== 1'b0 || measured_period !== 4'd9) begin
      n_fail++;
      $display("FAIL sat_state: got locked=%0b per=%0d want 0 9",
               locked, measured_period);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_interval();
    test_timeout();
    test_clk_en();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
